// File: rtl/wb_slave_mux.sv
// Single-master to num_slaves Wishbone B4 router with base/mask decode,
// unmapped-address error, stall handling and a watchdog that turns a hung slave into wb_err.
module wb_slave_mux #(
  parameter int addr_width     = 32,
  parameter int data_width     = 32,
  parameter int num_slaves     = 2,
  parameter logic [num_slaves*addr_width-1:0] slave_addr = {32'h8000_0000, 32'h0000_0000},
  parameter logic [num_slaves*addr_width-1:0] slave_mask = {32'hF000_0000, 32'hF000_0000},
  parameter int timeout_cycles = 255
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [addr_width-1:0]               wb_adr,
  input  logic [data_width-1:0]               wb_datwr,
  input  logic                                wb_we,
  input  logic [data_width/8-1:0]             wb_sel,
  input  logic                                wb_cyc,
  input  logic                                wb_stb,
  output logic                                wb_ack,
  output logic                                wb_err,
  output logic [data_width-1:0]               wb_datrd,
  output logic [num_slaves-1:0]               s_cyc,
  output logic [num_slaves-1:0]               s_stb,
  output logic [num_slaves-1:0]               s_we,
  output logic [num_slaves*addr_width-1:0]    s_adr,
  output logic [num_slaves*data_width-1:0]    s_datwr,
  output logic [num_slaves*data_width/8-1:0]  s_sel,
  input  logic [num_slaves-1:0]               s_stall,
  input  logic [num_slaves-1:0]               s_ack,
  input  logic [num_slaves-1:0]               s_err,
  input  logic [num_slaves*data_width-1:0]    s_datrd
);

  // state | meaning
  // IDLE  | no transaction; decode master request
  // REQ   | s_stb asserted to selected slave, waiting for stall=0
  // WAIT  | request accepted, s_cyc held until slave ack/err
  // RESP  | wb_ack pulse to master
  // ERR   | wb_err pulse (unmapped, slave error, or watchdog)

  localparam int NS  = num_slaves;
  localparam int AW  = addr_width;
  localparam int DW  = data_width;
  localparam int SW  = data_width / 8;
  localparam int SIW = (NS > 1) ? $clog2(NS) : 1;
  localparam int WDW = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  localparam logic [WDW-1:0] WD_LIMIT = (timeout_cycles > 0) ? WDW'(timeout_cycles - 1) : '0;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_t;

  state_t         state;
  logic [SIW-1:0] sel_idx;
  logic [SIW-1:0] hit_idx;
  logic           hit;
  logic [WDW-1:0] wdog;
  logic           sel_stall, sel_ack, sel_err, sel_we;
  logic [DW-1:0]  sel_datrd;
  logic           resp_ok, resp_err, resp_ack, wd_fire, end_xfer;

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((wb_adr & slave_mask[i*AW +: AW]) == (slave_addr[i*AW +: AW] & slave_mask[i*AW +: AW])) begin
        hit     = 1'b1;
        hit_idx = SIW'(i);
      end
    end
  end

  // A response is only honoured once the request has been (or is being) accepted.
  always_comb begin
    sel_stall = s_stall[sel_idx];
    sel_ack   = s_ack[sel_idx];
    sel_err   = s_err[sel_idx];
    sel_we    = s_we[sel_idx];
    sel_datrd = s_datrd[sel_idx*DW +: DW];
    resp_ok   = (state == WAIT) || ((state == REQ) && !sel_stall);
    resp_err  = resp_ok && sel_err;
    resp_ack  = resp_ok && sel_ack && !sel_err;
    wd_fire   = (timeout_cycles > 0) && (wdog == WD_LIMIT);
    end_xfer  = !wb_cyc || resp_err || resp_ack || wd_fire;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wb_ack   <= 1'b0;
      wb_err   <= 1'b0;
      wb_datrd <= '0;
      s_cyc    <= '0;
      s_stb    <= '0;
      s_we     <= '0;
      s_adr    <= '0;
      s_datwr  <= '0;
      s_sel    <= '0;
      wdog     <= '0;
      sel_idx  <= '0;
    end else begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_cyc && wb_stb) begin
            if (hit) begin
              sel_idx                   <= hit_idx;
              wdog                      <= '0;
              s_cyc[hit_idx]            <= 1'b1;
              s_stb[hit_idx]            <= 1'b1;
              s_we[hit_idx]             <= wb_we;
              s_adr[hit_idx*AW +: AW]   <= wb_adr;
              s_datwr[hit_idx*DW +: DW] <= wb_datwr;
              s_sel[hit_idx*SW +: SW]   <= wb_sel;
              state                     <= REQ;
            end else begin
              wb_err <= 1'b1;
              state  <= ERR;
            end
          end
        end
        REQ, WAIT: begin
          if (end_xfer) begin
            s_cyc   <= '0;
            s_stb   <= '0;
            s_we    <= '0;
            s_adr   <= '0;
            s_datwr <= '0;
            s_sel   <= '0;
            // Abort wins over everything: silently return to IDLE.
            if (!wb_cyc) begin
              state <= IDLE;
            end else if (resp_err || (!resp_ack && wd_fire)) begin
              wb_err <= 1'b1;
              state  <= ERR;
            end else begin
              wb_ack <= 1'b1;
              if (!sel_we) wb_datrd <= sel_datrd;
              state  <= RESP;
            end
          end else begin
            if (wdog != '1) wdog <= wdog + 1'b1;
            if ((state == REQ) && !sel_stall) begin
              s_stb <= '0;
              state <= WAIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
